// File: rtl/stream_demux_pkg.sv
// Shared types and default widths for the 1-to-2 byte stream demultiplexer.
package stream_demux_pkg;

    typedef enum logic {
        LANE_B = 1'b0,
        LANE_A = 1'b1
    } lane_e;

    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefCntW  = 8;

endpackage

// File: rtl/stream_demux_lane.sv
// One output lane: a one-entry holding register, its space term and a
// saturating delivered-beat counter.
module stream_demux_lane
    import stream_demux_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned CNT_W  = DefCntW
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count,
    output logic              space
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              out_fire;

    assign out_fire = valid_q & out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        // A new beat may replace the one leaving this same cycle.
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (out_fire) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        count_d = count_q;
        if (out_fire && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign count     = count_q;
    assign space     = ~valid_q | out_ready;

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-2 demultiplexer: each accepted byte goes to lane A or B
// according to its per-beat select; lanes stall independently.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned CNT_W  = DefCntW
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_sel_i,
    output logic              in_ready_o,
    output logic              a_valid_o,
    output logic [DATA_W-1:0] a_data_o,
    input  logic              a_ready_i,
    output logic              b_valid_o,
    output logic [DATA_W-1:0] b_data_o,
    input  logic              b_ready_i,
    output logic [CNT_W-1:0]  a_count_o,
    output logic [CNT_W-1:0]  b_count_o
);

    lane_e sel_lane;
    logic  a_space, b_space;
    logic  in_fire;
    logic  load_a, load_b;

    assign sel_lane = lane_e'(in_sel_i);

    // Ready follows the selected lane only, never in_valid_i.
    always_comb begin
        in_ready_o = b_space;
        if (sel_lane == LANE_A) begin
            in_ready_o = a_space;
        end
    end

    assign in_fire = in_valid_i & in_ready_o;
    assign load_a  = in_fire & (sel_lane == LANE_A);
    assign load_b  = in_fire & (sel_lane == LANE_B);

    stream_demux_lane #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_lane_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load_a),
        .load_data (in_data_i),
        .out_ready (a_ready_i),
        .out_valid (a_valid_o),
        .out_data  (a_data_o),
        .count     (a_count_o),
        .space     (a_space)
    );

    stream_demux_lane #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_lane_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load_b),
        .load_data (in_data_i),
        .out_ready (b_ready_i),
        .out_valid (b_valid_o),
        .out_data  (b_data_o),
        .count     (b_count_o),
        .space     (b_space)
    );

    a_hold_stable: assert property (@(posedge clk) disable iff (!reset_n)
        (a_valid_o && !a_ready_i) |=> $stable(a_data_o));
    b_hold_stable: assert property (@(posedge clk) disable iff (!reset_n)
        (b_valid_o && !b_ready_i) |=> $stable(b_data_o));

    a_load_seen: assert property (@(posedge clk) disable iff (!reset_n)
        (in_fire && in_sel_i) |=> (a_valid_o && (a_data_o == $past(in_data_i))));
    b_load_seen: assert property (@(posedge clk) disable iff (!reset_n)
        (in_fire && !in_sel_i) |=> (b_valid_o && (b_data_o == $past(in_data_i))));

    a_count_sat: assert property (@(posedge clk) disable iff (!reset_n)
        (a_count_o == {CNT_W{1'b1}}) |=> (a_count_o == {CNT_W{1'b1}}));
    b_count_sat: assert property (@(posedge clk) disable iff (!reset_n)
        (b_count_o == {CNT_W{1'b1}}) |=> (b_count_o == {CNT_W{1'b1}}));

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Registered 1-to-2 demultiplexer for an 8-bit valid/ready stream; it is the inverse of the team's 2:1 byte mux.
- Each accepted input byte is steered by a per-beat select to lane A (`sel=1`) or lane B (`sel=0`).
- Each lane has its own one-entry output register, and each lane counts delivered beats with a saturating counter.
- Sits between a single producer and two independent consumers.

Parameters:
- DATA_W, 8, width of the data path.
- CNT_W, 8, width of each per-lane delivered-beat counter.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  reset; one clock domain, reset is asynchronous and active-low.
- in_valid_i  in  1  producer has a beat.
- in_data_i  in  DATA_W  beat payload.
- in_sel_i  in  1  lane select for this beat: 1 = lane A, 0 = lane B.
- in_ready_o  out  1  block accepts the beat this cycle.
- a_valid_o  out  1  lane A holds a beat.
- a_data_o  out  DATA_W  lane A payload.
- a_ready_i  in  1  lane A consumer accepts.
- b_valid_o  out  1  lane B holds a beat.
- b_data_o  out  DATA_W  lane B payload.
- b_ready_i  in  1  lane B consumer accepts.
- a_count_o  out  CNT_W  beats delivered on lane A.
- b_count_o  out  CNT_W  beats delivered on lane B.

Behaviour:
- Reset (async assert, sync deassert by the integrator) clears: `a_valid_o`, `b_valid_o`, `a_data_o`, `b_data_o`, `a_count_o`, `b_count_o`.
  - `in_ready_o` then reads 1, because both lanes are empty.
- Transfer definitions:
  - Input transfer (`in_fire`) = `in_valid_i & in_ready_o`.
  - Lane X output transfer = `x_valid_o & x_ready_i`.
- Ready rule: `in_ready_o = in_sel_i ? (~a_valid_o | a_ready_i) : (~b_valid_o | b_ready_i)`.
  - This is combinational from `in_sel_i` and the selected lane's ready.
  - `in_ready_o` must not depend on `in_valid_i`.
- Lane register, per lane X, on each clk edge:
  - Load when `in_fire` and `in_sel_i` selects X: `x_valid=1`, `x_data=in_data_i`.
  - Otherwise, if an output transfer occurs: `x_valid=0`, data held.
  - Otherwise: hold.
  - Load and drain in the same cycle means load wins: the old beat leaves and the new beat is presented next cycle.
- Latency: exactly 1 cycle from input transfer to `x_valid_o` high.
  - Full throughput of 1 beat/cycle per lane while that lane's consumer holds ready high.
- Independence: a stalled lane (valid=1, ready=0) blocks only beats selected to it. Beats selected to the other lane keep flowing.
- Payload stability: while `x_valid_o=1` and `x_ready_i=0`, `x_data_o` and `x_valid_o` hold stable.
- Counters: `x_count_o` increments on each lane X output transfer.
  - Saturates at all-ones and never wraps.
  - Both counters may increment in the same cycle.
- Input side behaviour:
  - `in_data_i` and `in_sel_i` are don't-care when `in_valid_i=0`.
  - The producer may change `in_sel_i` while stalled; `in_ready_o` follows it combinationally.
- Reset mid-operation: any held beats are discarded and counters go to 0 immediately on `reset_n` low, with no clock required.
- Assertions use the team's standard assert macros:
  - `a_valid_o` with `~a_ready_i` implies `a_data_o` is stable next cycle; the same for lane B.
  - `in_fire` with `in_sel_i` implies `a_valid_o` and `a_data_o==in_data_i` next cycle; the mirrored check for lane B.
  - A counter at max stays at max.

Decomposition:
- Package `stream_demux_pkg`:
  - `lane_e` enum: `LANE_B=0`, `LANE_A=1`.
  - Defaults for `DATA_W` and `CNT_W`.
- Sub-module `stream_demux_lane`: one-entry register, its ready term, and its saturating counter; instantiated twice.
- The top level holds the select decode, the `in_ready_o` mux, and the assertions.

Test Plan:
- Hold `reset_n=0`, then release → all valids 0, data 0, counts 0, `in_ready_o=1` for both `sel` values.
- Send 0x11 (`sel=1`), then 0x22 (`sel=0`), with both readies high → `a_data_o=0x11` one cycle after the first beat, `b_data_o=0x22` one cycle after the second; `a_count_o=1`, `b_count_o=1`.
- Hold `a_ready_i=0`, send 0x33 to A, then present 0x44 to A → `in_ready_o=0` while `sel=1`, `a_data_o` stays 0x33. Flip `sel` to 0 with 0x55 → accepted, `b_data_o=0x55` next cycle. Raise `a_ready_i` → 0x44 accepted.
- Stream 10 beats to A on back-to-back cycles with `a_ready_i=1` → 10 consecutive valid cycles, data in order, `a_count_o=10`.
- Preload `a_count_o` near max (CNT_W=8, 260 deliveries) → `a_count_o` stops at 255.
- Pull `reset_n` low mid-cycle with beats held in both lanes → both valids drop immediately, counts read 0, and no beat appears after release.
